// File: rtl/packetmem_sched_pkg.sv
// Shared types for the packet buffer ownership scheduler: buffer ids, per-buffer
// state encoding and the honoured-event bundle.
package packetmem_sched_pkg;

    localparam int unsigned BUF_ID_W    = 2;
    localparam int unsigned NUM_BUFS    = 3;
    localparam int unsigned QUEUE_DEPTH = 3;

    typedef logic [BUF_ID_W-1:0] buf_id_t;

    localparam buf_id_t BUF_NONE = 2'b00;
    localparam buf_id_t BUF_PING = 2'b01;
    localparam buf_id_t BUF_PANG = 2'b10;
    localparam buf_id_t BUF_PUNG = 2'b11;

    typedef enum logic [2:0] {
        ST_FREE     = 3'd0,
        ST_SN       = 3'd1,
        ST_WAIT_CPU = 3'd2,
        ST_CPU      = 3'd3,
        ST_WAIT_FWD = 3'd4,
        ST_FWD      = 3'd5
    } buf_state_e;

    // Agent pulses that arrived while the agent actually owned a buffer
    typedef struct packed {
        logic sn_done;
        logic cpu_acc;
        logic cpu_rej;
        logic fwd_done;
    } release_t;

    // Buffer id (1..3) to state-array index (0..2)
    function automatic logic [1:0] buf_idx(input buf_id_t id);
        return 2'(id - BUF_PING);
    endfunction

    // State-array index to buffer id, ping/pang/pung in index order
    function automatic buf_id_t idx_to_id(input int unsigned i);
        return (i == 0) ? BUF_PING : (i == 1) ? BUF_PANG : BUF_PUNG;
    endfunction

endpackage

// File: rtl/packetmem_sched_buf_id_fifo.sv
// Three-entry FIFO of buffer ids; no bypass, so a pushed id is poppable one cycle later.
module packetmem_sched_buf_id_fifo
    import packetmem_sched_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  buf_id_t din,
    input  logic    pop,
    output buf_id_t head,
    output logic    empty,
    output logic    full
);

    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 2;

    buf_id_t          mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full queue is still accepted when the head leaves in the same cycle
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        count_d = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CNT_W'(QUEUE_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !push_ok));
    end

endmodule

// File: rtl/packetmem_sched.sv
// Ownership scheduler for the ping/pang/pung packet buffers: hands buffers to the
// snooper, CPU and forwarder in turn and returns them to the free pool.
module packetmem_sched
    import packetmem_sched_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sn_done,
    input  logic                 cpu_acc,
    input  logic                 cpu_rej,
    input  logic                 fwd_done,
    output logic [1:0]           sn_sel,
    output logic [1:0]           cpu_sel,
    output logic [1:0]           fwd_sel,
    output logic                 sn_rdy,
    output logic                 cpu_rdy,
    output logic                 fwd_rdy,
    output logic [CNT_WIDTH-1:0] acc_cnt,
    output logic [CNT_WIDTH-1:0] rej_cnt
);

    buf_state_e           st_q [NUM_BUFS];
    buf_state_e           st_d [NUM_BUFS];
    logic [NUM_BUFS-1:0]  freed_q;
    logic [NUM_BUFS-1:0]  freed_d;
    buf_id_t              sn_sel_d;
    buf_id_t              cpu_sel_d;
    buf_id_t              fwd_sel_d;
    logic                 sn_rdy_d;
    logic                 cpu_rdy_d;
    logic                 fwd_rdy_d;
    logic [CNT_WIDTH-1:0] acc_cnt_d;
    logic [CNT_WIDTH-1:0] rej_cnt_d;
    logic                 sn_found;
    release_t             hon;

    logic    cq_pop;
    logic    fq_pop;
    buf_id_t cq_head;
    buf_id_t fq_head;
    logic    cq_empty;
    logic    fq_empty;
    logic    cq_full;
    logic    fq_full;

    packetmem_sched_buf_id_fifo u_cpu_q (
        .clk   (clk),
        .rst   (rst),
        .push  (hon.sn_done),
        .din   (sn_sel),
        .pop   (cq_pop),
        .head  (cq_head),
        .empty (cq_empty),
        .full  (cq_full)
    );

    packetmem_sched_buf_id_fifo u_fwd_q (
        .clk   (clk),
        .rst   (rst),
        .push  (hon.cpu_acc),
        .din   (cpu_sel),
        .pop   (fq_pop),
        .head  (fq_head),
        .empty (fq_empty),
        .full  (fq_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BUFS; i++) st_q[i] <= ST_FREE;
            freed_q <= '0;
            sn_sel  <= BUF_NONE;
            cpu_sel <= BUF_NONE;
            fwd_sel <= BUF_NONE;
            sn_rdy  <= 1'b0;
            cpu_rdy <= 1'b0;
            fwd_rdy <= 1'b0;
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else begin
            st_q    <= st_d;
            freed_q <= freed_d;
            sn_sel  <= sn_sel_d;
            cpu_sel <= cpu_sel_d;
            fwd_sel <= fwd_sel_d;
            sn_rdy  <= sn_rdy_d;
            cpu_rdy <= cpu_rdy_d;
            fwd_rdy <= fwd_rdy_d;
            acc_cnt <= acc_cnt_d;
            rej_cnt <= rej_cnt_d;
        end
    end

    // Next state: releases first, then allocation for agents idle this cycle
    always_comb begin
        hon.sn_done  = sn_done && (sn_sel != BUF_NONE);
        hon.cpu_acc  = cpu_acc && (cpu_sel != BUF_NONE);
        hon.cpu_rej  = cpu_rej && !cpu_acc && (cpu_sel != BUF_NONE);
        hon.fwd_done = fwd_done && (fwd_sel != BUF_NONE);

        st_d      = st_q;
        freed_d   = '0;
        sn_sel_d  = sn_sel;
        cpu_sel_d = cpu_sel;
        fwd_sel_d = fwd_sel;
        cq_pop    = 1'b0;
        fq_pop    = 1'b0;
        sn_found  = 1'b0;

        if (hon.sn_done) begin
            st_d[buf_idx(sn_sel)] = ST_WAIT_CPU;
            sn_sel_d = BUF_NONE;
        end
        if (hon.cpu_acc) begin
            st_d[buf_idx(cpu_sel)] = ST_WAIT_FWD;
            cpu_sel_d = BUF_NONE;
        end else if (hon.cpu_rej) begin
            st_d[buf_idx(cpu_sel)]    = ST_FREE;
            freed_d[buf_idx(cpu_sel)] = 1'b1;
            cpu_sel_d = BUF_NONE;
        end
        if (hon.fwd_done) begin
            st_d[buf_idx(fwd_sel)]    = ST_FREE;
            freed_d[buf_idx(fwd_sel)] = 1'b1;
            fwd_sel_d = BUF_NONE;
        end

        // A buffer freed on the previous edge sits out one cycle before reuse
        if (sn_sel == BUF_NONE) begin
            for (int unsigned i = 0; i < NUM_BUFS; i++) begin
                if (!sn_found && st_q[i] == ST_FREE && !freed_q[i]) begin
                    sn_found = 1'b1;
                    sn_sel_d = idx_to_id(i);
                    st_d[i]  = ST_SN;
                end
            end
        end
        if (cpu_sel == BUF_NONE && !cq_empty) begin
            cq_pop = 1'b1;
            cpu_sel_d = cq_head;
            st_d[buf_idx(cq_head)] = ST_CPU;
        end
        if (fwd_sel == BUF_NONE && !fq_empty) begin
            fq_pop = 1'b1;
            fwd_sel_d = fq_head;
            st_d[buf_idx(fq_head)] = ST_FWD;
        end
    end

    // Output next values
    always_comb begin
        sn_rdy_d  = (sn_sel_d != BUF_NONE);
        cpu_rdy_d = (cpu_sel_d != BUF_NONE);
        fwd_rdy_d = (fwd_sel_d != BUF_NONE);
        acc_cnt_d = acc_cnt + CNT_WIDTH'(hon.cpu_acc);
        rej_cnt_d = rej_cnt + CNT_WIDTH'(hon.cpu_rej);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(hon.sn_done && cq_full && !cq_pop));
            assert (!(hon.cpu_acc && fq_full && !fq_pop));
        end
    end

endmodule
